// File: rtl/e203_tcm_banked_ram.sv
// e203_tcm_banked_ram
// Banked TCM SRAM shared by an instruction-fetch port (A, read-only) and a
// load/store port (B, read/write with byte mask). Each bank is single ported.
// Requests to different banks proceed in parallel. Same-bank conflicts go to
// a round-robin winner. Idle banks drop into light sleep under a per-bank
// idle timer, and any request wakes them again.

module e203_tcm_banked_ram #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MW      = DW / 8,
  parameter int NB      = 2,
  parameter int OUT_REG = 0,
  parameter int IDLE_LS = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ls_en_i,
  // port A: instruction fetch, read only
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [AW-1:0] a_addr_i,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  // port B: load/store
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [MW-1:0] b_wem_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rdata_o,
  // per-bank light-sleep status
  output logic [NB-1:0] bank_ls_o
);

  // Bank-select bits sit at the bottom of the word address, so consecutive
  // words interleave across banks.
  localparam int BW       = (NB > 1) ? $clog2(NB) : 0;
  localparam int SW       = (BW > 0) ? BW : 1;
  localparam int RW       = AW - BW;
  localparam int DEPTH    = 1 << RW;
  localparam int CW       = (IDLE_LS > 0) ? $clog2(IDLE_LS + 1) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_LS);

  typedef enum logic [1:0] {
    BANK_ACTIVE = 2'd0,
    BANK_SLEEP  = 2'd1,
    BANK_WAKE   = 2'd2
  } bank_state_e;

  // Merge write data into the old word, one byte lane per mask bit.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [MW-1:0] wem);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < MW; i++) begin
      if (wem[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Address decode
  logic [SW-1:0] a_bank_s;
  logic [SW-1:0] b_bank_s;
  logic [RW-1:0] a_row_s;
  logic [RW-1:0] b_row_s;

  // Arbitration and per-bank results
  logic          rr_a_q;     // 1: port A wins the next conflict, 0: port B wins
  logic          rr_a_d;
  logic [NB-1:0] a_gnt_s;
  logic [NB-1:0] b_gnt_s;
  logic [NB-1:0] cfl_s;      // granted conflict in this bank this cycle
  logic [DW-1:0] bank_rd_s [NB];

  // First response stage
  logic          a_rv1_q;
  logic          a_rv1_d;
  logic          b_rv1_q;
  logic          b_rv1_d;
  logic [DW-1:0] a_rd1_q;
  logic [DW-1:0] a_rd1_d;
  logic [DW-1:0] b_rd1_q;
  logic [DW-1:0] b_rd1_d;

  // Split each word address into a bank index and a row within that bank.
  always_comb begin
    a_bank_s = '0;
    b_bank_s = '0;
    if (NB > 1) begin
      a_bank_s = a_addr_i[SW-1:0];
      b_bank_s = b_addr_i[SW-1:0];
    end else begin
      a_bank_s = '0;
      b_bank_s = '0;
    end
    a_row_s = a_addr_i[AW-1:BW];
    b_row_s = b_addr_i[AW-1:BW];
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    bank_state_e   st_q;
    bank_state_e   st_d;
    logic [CW-1:0] idle_q;
    logic [CW-1:0] idle_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          a_hit_s;
    logic          b_hit_s;
    logic          act_s;
    logic [RW-1:0] row_s;

    assign a_hit_s = a_valid_i && (a_bank_s == SW'(g));
    assign b_hit_s = b_valid_i && (b_bank_s == SW'(g));
    // Only an awake bank accepts work. Reset forces ready low.
    assign act_s   = (st_q == BANK_ACTIVE) && !rst_i;

    assign a_gnt_s[g] = act_s && a_hit_s && (!b_hit_s || rr_a_q);
    assign b_gnt_s[g] = act_s && b_hit_s && (!a_hit_s || !rr_a_q);
    assign cfl_s[g]   = act_s && a_hit_s && b_hit_s;

    // The bank's single port serves whichever requester won it this cycle.
    assign row_s        = a_gnt_s[g] ? a_row_s : b_row_s;
    assign bank_rd_s[g] = mem_q[row_s];
    assign bank_ls_o[g] = (st_q == BANK_SLEEP);

    // Byte-masked write into this bank's storage; contents are never reset.
    always_ff @(posedge clk_i) begin
      if (b_gnt_s[g] && b_we_i) begin
        mem_q[b_row_s] <= merge_bytes(mem_q[b_row_s], b_wdata_i, b_wem_i);
      end
    end

    // Light-sleep state machine and idle counter for this bank.
    always_comb begin
      st_d   = st_q;
      idle_d = idle_q;
      case (st_q)
        BANK_ACTIVE: begin
          if (a_gnt_s[g] || b_gnt_s[g]) begin
            idle_d = '0;
          end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + CW'(1);
          end else begin
            idle_d = idle_q;
          end
          // A request arriving on the expiry cycle keeps the bank awake.
          if (ls_en_i && (IDLE_LS != 0) && (idle_q == IDLE_MAX) && !a_hit_s && !b_hit_s) begin
            st_d = BANK_SLEEP;
          end else begin
            st_d = BANK_ACTIVE;
          end
        end
        BANK_SLEEP: begin
          if (a_hit_s || b_hit_s || !ls_en_i) begin
            st_d = BANK_WAKE;
          end else begin
            st_d = BANK_SLEEP;
          end
        end
        BANK_WAKE: begin
          st_d   = BANK_ACTIVE;
          idle_d = '0;
        end
        default: begin
          st_d   = BANK_ACTIVE;
          idle_d = '0;
        end
      endcase
    end

    // Bank state and idle counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        st_q   <= BANK_ACTIVE;
        idle_q <= '0;
      end else begin
        st_q   <= st_d;
        idle_q <= idle_d;
      end
    end
  end

  // Port ready is the OR of per-bank grants.
  assign a_ready_o = |a_gnt_s;
  assign b_ready_o = |b_gnt_s;

  // Round-robin pointer update and first response stage capture.
  always_comb begin
    a_rv1_d = |a_gnt_s;
    b_rv1_d = |b_gnt_s;
    rr_a_d  = rr_a_q;
    a_rd1_d = a_rd1_q;
    b_rd1_d = b_rd1_q;
    if (|cfl_s) begin
      rr_a_d = ~rr_a_q;
    end else begin
      rr_a_d = rr_a_q;
    end
    if (a_rv1_d) begin
      a_rd1_d = bank_rd_s[a_bank_s];
    end else begin
      a_rd1_d = a_rd1_q;
    end
    // Write responses return zero data. Idle cycles hold the last read.
    if (b_rv1_d) begin
      if (b_we_i) begin
        b_rd1_d = '0;
      end else begin
        b_rd1_d = bank_rd_s[b_bank_s];
      end
    end else begin
      b_rd1_d = b_rd1_q;
    end
  end

  // Arbitration pointer (favours B after reset) and first response stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_a_q  <= 1'b0;
      a_rv1_q <= 1'b0;
      b_rv1_q <= 1'b0;
      a_rd1_q <= '0;
      b_rd1_q <= '0;
    end else begin
      rr_a_q  <= rr_a_d;
      a_rv1_q <= a_rv1_d;
      b_rv1_q <= b_rv1_d;
      a_rd1_q <= a_rd1_d;
      b_rd1_q <= b_rd1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          a_rv2_q;
    logic          b_rv2_q;
    logic [DW-1:0] a_rd2_q;
    logic [DW-1:0] b_rd2_q;

    // Optional output stage; data only advances with a valid response.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        a_rv2_q <= 1'b0;
        b_rv2_q <= 1'b0;
        a_rd2_q <= '0;
        b_rd2_q <= '0;
      end else begin
        a_rv2_q <= a_rv1_q;
        b_rv2_q <= b_rv1_q;
        if (a_rv1_q) begin
          a_rd2_q <= a_rd1_q;
        end
        if (b_rv1_q) begin
          b_rd2_q <= b_rd1_q;
        end
      end
    end

    assign a_rvalid_o = a_rv2_q;
    assign a_rdata_o  = a_rd2_q;
    assign b_rvalid_o = b_rv2_q;
    assign b_rdata_o  = b_rd2_q;
  end else begin : g_no_out_reg
    assign a_rvalid_o = a_rv1_q;
    assign a_rdata_o  = a_rd1_q;
    assign b_rvalid_o = b_rv1_q;
    assign b_rdata_o  = b_rd1_q;
  end

endmodule

// File: tb/tb_e203_tcm_banked_ram.sv
// Directed bench for e203_tcm_banked_ram.
// dut0: NB=2, OUT_REG=0, IDLE_LS=4.
// dut1: NB=2, OUT_REG=1, sleep disabled.
// Inputs change at the falling edge. Checks run 1 ns later.

module tb_e203_tcm_banked_ram;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int NB = 2;

  logic          clk;
  logic          rst;
  logic          ls_en;
  logic          a_valid, a_ready, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [MW-1:0] b_wem;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [NB-1:0] bank_ls;

  logic          c_a_ready, c_a_rvalid;
  logic [DW-1:0] c_a_rdata;
  logic          c_b_valid, c_b_ready, c_b_we, c_b_rvalid;
  logic [AW-1:0] c_b_addr;
  logic [MW-1:0] c_b_wem;
  logic [DW-1:0] c_b_wdata, c_b_rdata;
  logic [NB-1:0] c_bank_ls;

  int n_checks;
  int n_errors;

  e203_tcm_banked_ram #(.AW(AW), .DW(DW), .MW(MW), .NB(NB), .OUT_REG(0), .IDLE_LS(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .ls_en_i(ls_en),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr),
    .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wem_i(b_wem), .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .bank_ls_o(bank_ls)
  );

  e203_tcm_banked_ram #(.AW(AW), .DW(DW), .MW(MW), .NB(NB), .OUT_REG(1), .IDLE_LS(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .ls_en_i(1'b0),
    .a_valid_i(1'b0), .a_ready_o(c_a_ready), .a_addr_i(8'd0),
    .a_rvalid_o(c_a_rvalid), .a_rdata_o(c_a_rdata),
    .b_valid_i(c_b_valid), .b_ready_o(c_b_ready), .b_we_i(c_b_we), .b_addr_i(c_b_addr),
    .b_wem_i(c_b_wem), .b_wdata_i(c_b_wdata), .b_rvalid_o(c_b_rvalid), .b_rdata_o(c_b_rdata),
    .bank_ls_o(c_bank_ls)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic [AW-1:0] addr);
    a_valid = v;
    a_addr  = addr;
  endtask

  task automatic drv_b(input logic v, input logic we, input logic [AW-1:0] addr,
                       input logic [MW-1:0] wem, input logic [DW-1:0] wdata);
    b_valid = v;
    b_we    = we;
    b_addr  = addr;
    b_wem   = wem;
    b_wdata = wdata;
  endtask

  task automatic drv_c(input logic v, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    c_b_valid = v;
    c_b_we    = we;
    c_b_addr  = addr;
    c_b_wem   = 4'hF;
    c_b_wdata = wdata;
  endtask

  task automatic idle();
    drv_a(1'b0, 8'd0);
    drv_b(1'b0, 1'b0, 8'd0, 4'h0, 32'h0);
    drv_c(1'b0, 1'b0, 8'd0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    ls_en    = 1'b0;
    idle();
    // Requests pending while reset is held must not be accepted.
    drv_a(1'b1, 8'd4);
    drv_b(1'b1, 1'b0, 8'd6, 4'h0, 32'h0);

    @(negedge clk); #1;
    chk("rst_a_ready",  a_ready,  32'd0);
    chk("rst_b_ready",  b_ready,  32'd0);
    chk("rst_a_rvalid", a_rvalid, 32'd0);
    chk("rst_b_rvalid", b_rvalid, 32'd0);
    chk("rst_a_rdata",  a_rdata,  32'd0);
    chk("rst_b_rdata",  b_rdata,  32'd0);
    chk("rst_bank_ls",  bank_ls,  32'd0);

    @(negedge clk); rst = 1'b0; idle();

    // Parallel banks
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd1, 4'hF, 32'h0000_1111); #1;
    chk("pre_b_ready", b_ready, 32'd1);
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd4, 4'hF, 32'hDEAD_BEEF); drv_a(1'b1, 8'd1); #1;
    chk("par_a_ready", a_ready, 32'd1);
    chk("par_b_ready", b_ready, 32'd1);
    chk("wr_rsp_valid", b_rvalid, 32'd1);
    chk("wr_rsp_data",  b_rdata,  32'd0);
    @(negedge clk); drv_b(1'b0, 1'b0, 8'd0, 4'h0, 32'h0); drv_a(1'b1, 8'd4); #1;
    chk("par_a_rvalid", a_rvalid, 32'd1);
    chk("par_a_rdata",  a_rdata,  32'h0000_1111);
    chk("par_b_rvalid", b_rvalid, 32'd1);
    chk("raw_a_ready",  a_ready,  32'd1);
    @(negedge clk); idle(); #1;
    chk("raw_a_rvalid", a_rvalid, 32'd1);
    chk("raw_a_rdata",  a_rdata,  32'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("hold_a_rvalid", a_rvalid, 32'd0);
    chk("hold_a_rdata",  a_rdata,  32'hDEAD_BEEF);

    // Byte mask, including an all-zero mask no-op write
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd6, 4'hF, 32'h1122_3344);
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd6, 4'b0101, 32'hAABB_CCDD);
    @(negedge clk); drv_b(1'b1, 1'b1, 8'd6, 4'b0000, 32'hFFFF_FFFF);
    @(negedge clk); drv_b(1'b0, 1'b0, 8'd0, 4'h0, 32'h0); drv_a(1'b1, 8'd6); #1;
    chk("nop_wr_rvalid", b_rvalid, 32'd1);
    chk("nop_wr_rdata",  b_rdata,  32'd0);
    @(negedge clk); drv_a(1'b0, 8'd0); drv_b(1'b1, 1'b0, 8'd6, 4'h0, 32'h0); #1;
    chk("mask_a_rvalid", a_rvalid, 32'd1);
    chk("mask_a_rdata",  a_rdata,  32'h11BB_33DD);
    @(negedge clk); idle(); #1;
    chk("mask_b_rvalid", b_rvalid, 32'd1);
    chk("mask_b_rdata",  b_rdata,  32'h11BB_33DD);

    // Conflict on bank 0 for four cycles: grants B, A, B, A
    @(negedge clk); drv_a(1'b1, 8'd4); drv_b(1'b1, 1'b0, 8'd6, 4'h0, 32'h0); #1;
    chk("cfl1_a_ready", a_ready, 32'd0);
    chk("cfl1_b_ready", b_ready, 32'd1);
    @(negedge clk); #1;
    chk("cfl2_a_ready", a_ready, 32'd1);
    chk("cfl2_b_ready", b_ready, 32'd0);
    chk("cfl2_b_rvalid", b_rvalid, 32'd1);
    chk("cfl2_b_rdata",  b_rdata,  32'h11BB_33DD);
    chk("cfl2_a_rvalid", a_rvalid, 32'd0);
    @(negedge clk); #1;
    chk("cfl3_a_ready", a_ready, 32'd0);
    chk("cfl3_b_ready", b_ready, 32'd1);
    chk("cfl3_a_rvalid", a_rvalid, 32'd1);
    chk("cfl3_a_rdata",  a_rdata,  32'hDEAD_BEEF);
    chk("cfl3_b_rvalid", b_rvalid, 32'd0);
    @(negedge clk); #1;
    chk("cfl4_a_ready", a_ready, 32'd1);
    chk("cfl4_b_ready", b_ready, 32'd0);
    chk("cfl4_b_rvalid", b_rvalid, 32'd1);
    chk("cfl4_a_rvalid", a_rvalid, 32'd0);
    @(negedge clk); idle(); #1;
    chk("cfl5_a_rvalid", a_rvalid, 32'd1);
    chk("cfl5_b_rvalid", b_rvalid, 32'd0);
    @(negedge clk); #1;
    chk("cfl6_a_rvalid", a_rvalid, 32'd0);
    chk("cfl6_b_rvalid", b_rvalid, 32'd0);

    // Light sleep and wake
    @(negedge clk); ls_en = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("sleep_bank_ls", bank_ls, 32'd3);
    @(negedge clk); drv_a(1'b1, 8'd1); #1;
    chk("slp_a_ready", a_ready, 32'd0);
    chk("slp_bank_ls", bank_ls, 32'd3);
    @(negedge clk); #1;
    chk("wake_a_ready", a_ready, 32'd0);
    chk("wake_bank_ls", bank_ls, 32'd1);
    @(negedge clk); #1;
    chk("act_a_ready", a_ready, 32'd1);
    chk("act_bank_ls", bank_ls, 32'd1);
    @(negedge clk); drv_a(1'b0, 8'd0); ls_en = 1'b0; #1;
    chk("slp_a_rvalid", a_rvalid, 32'd1);
    chk("slp_a_rdata",  a_rdata,  32'h0000_1111);
    @(negedge clk);
    @(negedge clk); #1;
    chk("unslp_bank_ls", bank_ls, 32'd0);

    // Reset right after a grant drops the response
    @(negedge clk); drv_a(1'b1, 8'd4); #1;
    chk("mid_a_ready", a_ready, 32'd1);
    @(posedge clk); #1; rst = 1'b1; drv_b(1'b1, 1'b0, 8'd6, 4'h0, 32'h0);
    @(negedge clk); #1;
    chk("mid_rst_a_ready",  a_ready,  32'd0);
    chk("mid_rst_b_ready",  b_ready,  32'd0);
    chk("mid_rst_a_rvalid", a_rvalid, 32'd0);
    chk("mid_rst_b_rvalid", b_rvalid, 32'd0);
    chk("mid_rst_a_rdata",  a_rdata,  32'd0);
    chk("mid_rst_bank_ls",  bank_ls,  32'd0);
    @(negedge clk); rst = 1'b0; idle(); #1;
    chk("post_rst_a_rvalid", a_rvalid, 32'd0);
    @(negedge clk); drv_a(1'b1, 8'd4); #1;
    chk("post_rst_a_ready",   a_ready,  32'd1);
    chk("post_rst_a_rvalid2", a_rvalid, 32'd0);
    @(negedge clk); idle(); #1;
    chk("post_rst_rvalid", a_rvalid, 32'd1);
    chk("post_rst_rdata",  a_rdata,  32'hDEAD_BEEF);

    // Output register: two-cycle latency, back-to-back B reads
    @(negedge clk); drv_c(1'b1, 1'b1, 8'd0, 32'hA0A0_0000); #1;
    chk("or_wr_ready", c_b_ready, 32'd1);
    @(negedge clk); drv_c(1'b1, 1'b1, 8'd1, 32'hA1A1_0001);
    @(negedge clk); drv_c(1'b1, 1'b1, 8'd2, 32'hA2A2_0002);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk); #1;
    chk("or_drain_rvalid", c_b_rvalid, 32'd0);
    @(negedge clk); drv_c(1'b1, 1'b0, 8'd0, 32'h0); #1;
    chk("or_g0_ready", c_b_ready, 32'd1);
    @(negedge clk); drv_c(1'b1, 1'b0, 8'd1, 32'h0); #1;
    chk("or_g1_rvalid", c_b_rvalid, 32'd0);
    @(negedge clk); drv_c(1'b1, 1'b0, 8'd2, 32'h0); #1;
    chk("or_g2_rvalid", c_b_rvalid, 32'd1);
    chk("or_g2_rdata",  c_b_rdata,  32'hA0A0_0000);
    @(negedge clk); idle(); #1;
    chk("or_g3_rvalid", c_b_rvalid, 32'd1);
    chk("or_g3_rdata",  c_b_rdata,  32'hA1A1_0001);
    @(negedge clk); #1;
    chk("or_g4_rvalid", c_b_rvalid, 32'd1);
    chk("or_g4_rdata",  c_b_rdata,  32'hA2A2_0002);
    @(negedge clk); #1;
    chk("or_g5_rvalid", c_b_rvalid, 32'd0);
    chk("or_g5_rdata",  c_b_rdata,  32'hA2A2_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
